// File: rtl/lut_loader_pkg.sv
// Shared DDS configuration: sample width, LUT depth and phase width.
// The LUT loader and the DDS core both take their defaults from here.
package lut_loader_pkg;
  localparam int DDS_DATA_LEN    = 8;
  localparam int DDS_ROWS_BASE_2 = 8;
  localparam int DDS_PHASE_W     = 9;
endpackage

// File: rtl/lut_addr_counter.sv
// LUT row counter with clear, increment and a sticky terminal flag.
// The extra top bit marks "all rows taken" so the count never wraps.
module lut_addr_counter
  import lut_loader_pkg::*;
#(
  parameter int W = DDS_ROWS_BASE_2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] addr,
  output logic         tc
);

  logic [W:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !cnt[W]) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign addr = cnt[W-1:0];
  assign tc   = cnt[W];

endmodule

// File: rtl/lut_loader.sv
// Streams a full sine table into the DDS LUT, then strobes the start
// phase and pulses done. Abort or reset drops the load in progress.
module lut_loader
  import lut_loader_pkg::*;
#(
  parameter int DATA_LEN    = DDS_DATA_LEN,
  parameter int ROWS_BASE_2 = DDS_ROWS_BASE_2,
  parameter int PHASE_W     = DDS_PHASE_W
) (
  input  logic                   src_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_W-1:0]     phase_cfg,
  input  logic                   s_valid,
  input  logic [DATA_LEN-1:0]    s_data,
  output logic                   s_ready,
  output logic [DATA_LEN-1:0]    data_wr,
  output logic [ROWS_BASE_2-1:0] addr_wr,
  output logic                   we,
  output logic                   set_phase,
  output logic [PHASE_W-1:0]     phase,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETPH,
    DONE
  } state_t;

  state_t state, state_n;

  logic                   clr;
  logic                   take;
  logic                   tc;
  logic [ROWS_BASE_2-1:0] row;
  logic [PHASE_W-1:0]     ph_lat;
  logic [PHASE_W-1:0]     phase_q;

  lut_addr_counter #(
    .W (ROWS_BASE_2)
  ) u_cnt (
    .clk  (src_clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (take),
    .addr (row),
    .tc   (tc)
  );

  // LOAD stays one extra cycle once tc rises so the last write
  // lands before set_phase.
  always_comb begin
    state_n   = state;
    clr       = 1'b0;
    s_ready   = 1'b0;
    set_phase = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          clr     = 1'b1;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_n = IDLE;
        end else begin
          s_ready = !tc;
          if (tc) state_n = SETPH;
        end
      end
      SETPH: begin
        busy = 1'b1;
        if (abort) begin
          state_n = IDLE;
        end else begin
          set_phase = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign take  = s_valid & s_ready;
  assign phase = set_phase ? ph_lat : phase_q;

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ph_lat  <= '0;
      phase_q <= '0;
      we      <= 1'b0;
      data_wr <= '0;
      addr_wr <= '0;
    end else begin
      state <= state_n;
      we    <= take;
      if (state == IDLE && start) ph_lat <= phase_cfg;
      if (set_phase) phase_q <= ph_lat;
      if (take) begin
        data_wr <= s_data;
        addr_wr <= row;
      end
    end
  end

endmodule

// File: tb/tb_lut_loader.sv
// Directed bench for lut_loader: table of load scenarios plus
// hand sequences for reset state and mid-load reset.
module tb_lut_loader;
  localparam int DL   = 8;
  localparam int RB   = 8;
  localparam int PW   = 9;
  localparam int ROWS = 256;

  logic          src_clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] phase_cfg = '0;
  logic          s_valid = 1'b0;
  logic [DL-1:0] s_data = '0;
  logic          s_ready;
  logic [DL-1:0] data_wr;
  logic [RB-1:0] addr_wr;
  logic          we;
  logic          set_phase;
  logic [PW-1:0] phase;
  logic          busy;
  logic          done;

  lut_loader #(
    .DATA_LEN    (DL),
    .ROWS_BASE_2 (RB),
    .PHASE_W     (PW)
  ) dut (
    .src_clk   (src_clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .phase_cfg (phase_cfg),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .data_wr   (data_wr),
    .addr_wr   (addr_wr),
    .we        (we),
    .set_phase (set_phase),
    .phase     (phase),
    .busy      (busy),
    .done      (done)
  );

  always #5 src_clk = ~src_clk;

  logic [DL-1:0] tbl [ROWS];
  logic [DL-1:0] mem [ROWS];

  int n_vec = 0;
  int n_bad = 0;

  int wr_cnt = 0, consec = 0, sp_cnt = 0, done_cnt = 0;
  int addr_err = 0, data_err = 0, overlap = 0;
  int cyc_n = 0, lw_cyc = 0, sp_cyc = 0, done_cyc = 0;
  logic          prev_we = 1'b0;
  logic [RB:0]   exp_addr = '0;
  logic [PW-1:0] sp_val = '0;

  always @(negedge src_clk) begin
    if (rst) begin
      exp_addr <= '0;
      prev_we  <= 1'b0;
    end else begin
      cyc_n   <= cyc_n + 1;
      prev_we <= we;
      if (we) begin
        wr_cnt        <= wr_cnt + 1;
        lw_cyc        <= cyc_n;
        mem[addr_wr]  <= data_wr;
        exp_addr      <= exp_addr + 1'b1;
        if (addr_wr != exp_addr[RB-1:0]) addr_err <= addr_err + 1;
        if (data_wr != tbl[addr_wr]) data_err <= data_err + 1;
        if (prev_we) consec <= consec + 1;
      end
      if (start && !busy && !done) exp_addr <= '0;
      if (set_phase) begin
        sp_cnt <= sp_cnt + 1;
        sp_cyc <= cyc_n;
        sp_val <= phase;
      end
      if (we && set_phase) overlap <= overlap + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc_n;
      end
    end
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_wr"}, data_wr, 0);
    chk({tag, "_addr_wr"}, addr_wr, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_set_phase"}, set_phase, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode 0: valid held, 1: valid toggles, 2: abort, 3: restart spam
  task automatic run_load(input int mode, input logic [PW-1:0] ph,
                          input int ab);
    int   idx = 0;
    int   cyc = 0;
    logic fired;
    @(posedge src_clk); #1;
    start = 1'b1;
    phase_cfg = ph;
    @(posedge src_clk); #1;
    start = 1'b0;
    while (idx < ROWS && cyc < 3000) begin
      s_valid = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      s_data  = tbl[idx];
      abort   = (idx == ab);
      if (mode == 3) begin
        start     = (cyc % 5 == 0);
        phase_cfg = 9'd180;
      end
      @(negedge src_clk);
      fired = s_valid & s_ready;
      @(posedge src_clk); #1;
      if (fired) idx++;
      cyc++;
      if (abort) begin
        abort   = 1'b0;
        s_valid = 1'b0;
        start   = 1'b0;
        @(negedge src_clk);
        chk("busy_after_abort", busy, 0);
        break;
      end
    end
    s_valid = 1'b0;
    start   = 1'b0;
    repeat (8) @(posedge src_clk);
    #1;
  endtask

  typedef struct {
    int            mode;
    logic [PW-1:0] ph;
    int            ab;
    int            wr;
    int            sp;
    int            dn;
    int            cons;
    logic [PW-1:0] phx;
  } vec_t;

  vec_t vt [5];

  initial begin
    int w0, c0, s0, d0, a0, e0, o0, bad;
    for (int i = 0; i < ROWS; i++) begin
      tbl[i] = DL'(int'(127.0 * $sin(6.283185307 * i / 256.0)) + 128);
      mem[i] = '0;
    end
    vt[0] = '{0, 9'd90,  -1,  256, 1, 1, 255, 9'd90};
    vt[1] = '{1, 9'd300, -1,  256, 1, 1, 0,   9'd300};
    vt[2] = '{2, 9'd77,  100, 100, 0, 0, 99,  9'd300};
    vt[3] = '{3, 9'd33,  -1,  256, 1, 1, 255, 9'd33};
    vt[4] = '{0, 9'd511, -1,  256, 1, 1, 255, 9'd511};

    repeat (3) @(posedge src_clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      w0 = wr_cnt; c0 = consec; s0 = sp_cnt; d0 = done_cnt;
      a0 = addr_err; e0 = data_err; o0 = overlap;
      run_load(vt[v].mode, vt[v].ph, vt[v].ab);
      chk($sformatf("v%0d_writes", v), wr_cnt - w0, vt[v].wr);
      chk($sformatf("v%0d_back2back", v), consec - c0, vt[v].cons);
      chk($sformatf("v%0d_set_phase", v), sp_cnt - s0, vt[v].sp);
      chk($sformatf("v%0d_done", v), done_cnt - d0, vt[v].dn);
      chk($sformatf("v%0d_addr_err", v), addr_err - a0, 0);
      chk($sformatf("v%0d_data_err", v), data_err - e0, 0);
      chk($sformatf("v%0d_overlap", v), overlap - o0, 0);
      chk($sformatf("v%0d_phase", v), phase, vt[v].phx);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      if (vt[v].sp == 1) begin
        chk($sformatf("v%0d_sp_val", v), sp_val, vt[v].ph);
        chk($sformatf("v%0d_sp_gap", v), sp_cyc - lw_cyc, 1);
        chk($sformatf("v%0d_done_gap", v), done_cyc - sp_cyc, 1);
      end
    end

    // reset in the middle of a load, then reload from scratch
    for (int i = 0; i < ROWS; i++) mem[i] = '0;
    @(posedge src_clk); #1;
    start = 1'b1;
    phase_cfg = 9'd200;
    @(posedge src_clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      s_data = tbl[i];
      @(posedge src_clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    s_valid = 1'b0;
    @(posedge src_clk); #1;
    rst = 1'b0;
    w0 = wr_cnt; a0 = addr_err; e0 = data_err; s0 = sp_cnt;
    run_load(0, 9'd45, -1);
    chk("reload_writes", wr_cnt - w0, 256);
    chk("reload_addr_err", addr_err - a0, 0);
    chk("reload_data_err", data_err - e0, 0);
    chk("reload_set_phase", sp_cnt - s0, 1);
    chk("reload_phase", phase, 45);
    bad = 0;
    for (int i = 0; i < ROWS; i++) if (mem[i] !== tbl[i]) bad++;
    chk("lut_contents", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lut_loader.md
LUT_LOADER -- requirements
Module: lut_loader

Interface
REQ-001 Parameter DATA_LEN, default 8, sample width; SHALL match DDS data_wr width.
REQ-002 Parameter ROWS_BASE_2, default 8, LUT address width; SHALL match DDS addr_wr width.
REQ-003 Parameter PHASE_W, default 9, phase word width; SHALL match DDS phase width.
REQ-004 Port src_clk  in  1  sole clock, all state on rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port start  in  1  single-cycle request to begin a full LUT load.
REQ-007 Port abort  in  1  terminate load, return to IDLE, no phase set.
REQ-008 Port phase_cfg  in  PHASE_W  phase applied after load; sampled on accepted start.
REQ-009 Port s_valid  in  1  sample-stream valid.
REQ-010 Port s_data  in  DATA_LEN  sample value.
REQ-011 Port s_ready  out  1  loader accepts sample; transfer when s_valid & s_ready.
REQ-012 Port data_wr  out  DATA_LEN  DDS memory write data.
REQ-013 Port addr_wr  out  ROWS_BASE_2  DDS memory write address.
REQ-014 Port we  out  1  DDS memory write enable.
REQ-015 Port set_phase  out  1  DDS phase-load strobe.
REQ-016 Port phase  out  PHASE_W  DDS phase value.
REQ-017 Port busy  out  1  high in LOAD and SETPH.
REQ-018 Port done  out  1  one-cycle pulse on successful completion.

Function
REQ-019 States SHALL be IDLE, LOAD, SETPH, DONE; ROWS = 2**ROWS_BASE_2.
REQ-020 IDLE: start=1 -> LOAD; row counter cleared to 0; phase_cfg latched.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 s_ready SHALL equal 1 only in LOAD and low on the cycle after the final sample is accepted.
REQ-023 Accepted transfer in cycle N SHALL produce we=1, data_wr=s_data, addr_wr=row counter in cycle N+1 (one-cycle registered latency).
REQ-024 Row counter SHALL increment by 1 per accepted transfer; no other writes issued.
REQ-025 s_valid low in LOAD SHALL stall: we=0 next cycle, counter and addr_wr hold.
REQ-026 Accepting row ROWS-1 SHALL move LOAD -> SETPH; counter does not wrap into a second pass.
REQ-027 SETPH SHALL last exactly one cycle, entered the cycle after the last write (we and set_phase never high together): set_phase=1, phase=latched phase_cfg.
REQ-028 SETPH -> DONE; DONE SHALL assert done=1 one cycle, then -> IDLE.
REQ-029 phase SHALL hold its last applied value until next SETPH; set_phase=0 outside SETPH.
REQ-030 abort=1 in LOAD or SETPH SHALL force IDLE next cycle; pending write in flight completes, no set_phase, no done; abort has priority over start and s_valid.
REQ-031 Outside LOAD (except the trailing write cycle) we SHALL be 0; data_wr/addr_wr hold last value.
REQ-032 phase_cfg SHALL be passed through unmodified (no range check or modulo).

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, counter 0, data_wr 0, addr_wr 0, we 0, set_phase 0, phase 0, s_ready 0, busy 0, done 0.
REQ-034 Reset mid-load SHALL discard progress; the next start reloads from address 0.

Structure
REQ-035 DATA_LEN and ROWS_BASE_2 defaults SHALL come from the shared config header used by the DDS; state encoding local to lut_loader.
REQ-036 Row counter with increment/clear/terminal-count SHALL be one sub-module, lut_addr_counter.

Verification
REQ-037 start, phase_cfg=90, s_valid held high with s_data=row index -> 256 writes addr 0..255 on consecutive cycles, then set_phase=1 one cycle with phase=90, done pulse next cycle.
REQ-038 s_valid toggling 1/0 every cycle -> we pattern 1/0, addr_wr advances only on writes, 256 writes total, end state identical.
REQ-039 abort asserted after 100 accepted samples -> exactly 100 writes, set_phase and done never assert, busy low next cycle.
REQ-040 rst pulse after 50 samples, then start with phase_cfg=45 -> all outputs 0 during reset, reload begins at addr 0, final phase=45.
REQ-041 start asserted repeatedly during LOAD and phase_cfg changed to 180 -> ignored, applied phase remains value latched at original start.
REQ-042 Feed sine table (256 entries) into lut_loader driving DDS, phase_cfg=90 -> DDS sinwave output matches table shifted by 90.
